// File: rtl/circuit_tt_sweeper_if.sv
// Bus between the truth-table sweeper and its requester / circuit under test.
// Optional compare signals exist only when TT_COMPARE_EN is defined.
interface circuit_tt_sweeper_if #(
  parameter int N_IN = 4
);
  localparam int W = 1 << N_IN;

  logic            start;
  logic [N_IN-1:0] x_out;
  logic            f_in;
  logic            busy;
  logic            done;
  logic [W-1:0]    tt;
  logic            tt_valid;
`ifdef TT_COMPARE_EN
  logic [W-1:0]    exp_tt;
  logic            mismatch;

  modport master (output start, f_in, exp_tt,
                  input  x_out, busy, done, tt, tt_valid, mismatch);
  modport slave  (input  start, f_in, exp_tt,
                  output x_out, busy, done, tt, tt_valid, mismatch);
`else
  modport master (output start, f_in,
                  input  x_out, busy, done, tt, tt_valid);
  modport slave  (input  start, f_in,
                  output x_out, busy, done, tt, tt_valid);
`endif
endinterface

// File: rtl/circuit_tt_sweeper.sv
// Truth-table sweeper: walks x_out through 0..2**N_IN-1, holds each vector
// SETTLE+1 cycles, samples f_in in the last one and builds tt[v] = f(v).
// Optional feature macro: TT_COMPARE_EN (adds exp_tt compare -> mismatch).
module circuit_tt_sweeper #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2
) (
  input logic              clk,
  input logic              rst_n,
  circuit_tt_sweeper_if.slave bus
);
  localparam int W  = 1 << N_IN;
  localparam int CW = 4;
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]      state_q, state_d;
  // idx doubles as the driven vector: it is 0 at start and stays at all ones
  // after the sweep, exactly what x_out has to show.
  logic [N_IN-1:0] idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    tt_q, tt_d;
  logic            ttv_q, ttv_d;
`ifdef TT_COMPARE_EN
  logic            mm_q, mm_d;
`endif

  // Next-state: accept start in IDLE, count settle cycles, sample, finish.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    ttv_d   = ttv_q;
`ifdef TT_COMPARE_EN
    mm_d    = mm_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_DRIVE;
          idx_d   = '0;
          cnt_d   = SETTLE_C;
          tt_d    = '0;
          ttv_d   = 1'b0;
`ifdef TT_COMPARE_EN
          mm_d    = 1'b0;
`endif
        end
      end
      S_DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          tt_d[idx_q] = bus.f_in;
          if (idx_q == {N_IN{1'b1}}) begin
            state_d = S_DONE;
            ttv_d   = 1'b1;
`ifdef TT_COMPARE_EN
            // Compare includes the sample taken this very cycle.
            mm_d    = (tt_d != bus.exp_tt);
`endif
          end else begin
            idx_d = idx_q + N_IN'(1);
            cnt_d = SETTLE_C;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers, async active-low reset discards any partial sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      tt_q    <= '0;
      ttv_q   <= 1'b0;
`ifdef TT_COMPARE_EN
      mm_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
      ttv_q   <= ttv_d;
`ifdef TT_COMPARE_EN
      mm_q    <= mm_d;
`endif
    end
  end

  assign bus.x_out    = idx_q;
  assign bus.busy     = (state_q == S_DRIVE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.tt       = tt_q;
  assign bus.tt_valid = ttv_q;
`ifdef TT_COMPARE_EN
  assign bus.mismatch = mm_q;
`endif
endmodule

// File: tb/tb_circuit_tt_sweeper.sv
// Bench for circuit_tt_sweeper: one instance with SETTLE=2, one with SETTLE=0.
// A timing model (elapsed cycles since the accepted start) predicts every
// output each cycle; directed sweeps add literal truth-table/latency checks.
module tb_circuit_tt_sweeper;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int          mode = 0;
  logic [1:0]  st = '0;
  logic [15:0] ett = '0;
  int          checks = 0;
  int          errors = 0;

  // Circuit under characterisation, selected by mode.
  function automatic logic fn(int m, logic [3:0] x);
    case (m)
      1:       return x[0];
      2:       return x[3];
      3:       return x[1] & x[2];
      4:       return ^x;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] tbl(int m);
    logic [15:0] t;
    for (int v = 0; v < 16; v++) t[v] = fn(m, 4'(v));
    return t;
  endfunction

  function automatic int unsigned sv(int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic int unsigned dl(int i);
    return 16 * (sv(i) + 1);
  endfunction

  circuit_tt_sweeper_if #(.N_IN(4)) ifa();
  circuit_tt_sweeper_if #(.N_IN(4)) ifb();

  circuit_tt_sweeper #(.N_IN(4), .SETTLE(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  circuit_tt_sweeper #(.N_IN(4), .SETTLE(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  assign ifa.start = st[0];
  assign ifb.start = st[1];
  assign ifa.f_in  = fn(mode, ifa.x_out);
  assign ifb.f_in  = fn(mode, ifb.x_out);

  logic [3:0]  xo[2];
  logic        bo[2], dn[2], vo[2];
  logic [15:0] to[2];
  assign xo[0] = ifa.x_out;    assign xo[1] = ifb.x_out;
  assign bo[0] = ifa.busy;     assign bo[1] = ifb.busy;
  assign dn[0] = ifa.done;     assign dn[1] = ifb.done;
  assign vo[0] = ifa.tt_valid; assign vo[1] = ifb.tt_valid;
  assign to[0] = ifa.tt;       assign to[1] = ifb.tt;
`ifdef TT_COMPARE_EN
  logic mo[2];
  assign ifa.exp_tt = ett;
  assign ifb.exp_tt = ett;
  assign mo[0] = ifa.mismatch; assign mo[1] = ifb.mismatch;
`endif

  task automatic chk(string nm, int i, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, i, got, exp);
    end
  endtask

  // Model: when a start is accepted and how many cycles have elapsed since.
  int unsigned cyc = 0;
  int unsigned t0[2];
  bit          act[2];
  logic [15:0] full[2];
  bit          mmx[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0;
      for (int i = 0; i < 2; i++) begin
        act[i] <= 1'b0; t0[i] <= 0; full[i] <= '0; mmx[i] <= 1'b0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
        if (st[i] && (!act[i] || (cyc - t0[i]) >= dl(i) + 1)) begin
          act[i] <= 1'b1; t0[i] <= cyc + 1; full[i] <= tbl(mode); mmx[i] <= 1'b0;
        end else if (act[i] && (cyc + 1 - t0[i]) == dl(i)) begin
          mmx[i] <= (full[i] != ett);
        end
      end
    end
  end

  // Per-cycle compare of both instances against the model.
  logic [3:0]  ex;
  logic        eb, ed, ev, em;
  logic [15:0] et;
  int unsigned e, k;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      ex = '0; eb = 1'b0; ed = 1'b0; ev = 1'b0; et = '0; em = 1'b0;
      if (rst_n && act[i]) begin
        e = cyc - t0[i];
        if (e < dl(i)) begin
          k  = e / (sv(i) + 1);
          ex = 4'(k);
          eb = 1'b1;
          et = full[i] & 16'((32'd1 << k) - 32'd1);
        end else begin
          ex = 4'hF;
          ed = (e == dl(i));
          ev = 1'b1;
          et = full[i];
          em = mmx[i];
        end
      end
      chk("m_x_out", i, 32'(xo[i]), 32'(ex));
      chk("m_busy", i, 32'(bo[i]), 32'(eb));
      chk("m_done", i, 32'(dn[i]), 32'(ed));
      chk("m_tt_valid", i, 32'(vo[i]), 32'(ev));
      chk("m_tt", i, 32'(to[i]), 32'(et));
`ifdef TT_COMPARE_EN
      chk("m_mismatch", i, 32'(mo[i]), 32'(em));
`endif
    end
  end

  task automatic pulse(int i);
    @(negedge clk); st[i] = 1'b1;
    @(negedge clk); st[i] = 1'b0;
  endtask

  // Returns the cycle (1 = first after the start edge) in which done is seen.
  task automatic sweep(int i, output int lat);
    int n;
    pulse(i);
    n = 1;
    while (!dn[i] && n < 300) begin
      @(negedge clk); n++;
    end
    if (!dn[i]) begin
      errors++; checks++;
      $display("FAIL timeout[%0d]: no done within %0d cycles", i, n);
    end
    lat = n;
  endtask

  initial begin
    int lat, nd, d1, d2;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_x_out", 0, 32'(xo[0]), 0);
    chk("rst_tt", 0, 32'(to[0]), 0);
    chk("rst_busy", 0, 32'(bo[0]), 0);

    // f tied low
    mode = 0; sweep(0, lat);
    chk("lat_settle2", 0, lat, 49);
    chk("tt_zero", 0, 32'(to[0]), 32'h0000);
    chk("valid_at_done", 0, 32'(vo[0]), 1);
    @(negedge clk);
    chk("busy_after", 0, 32'(bo[0]), 0);
    chk("done_pulse", 0, 32'(dn[0]), 0);
    chk("x_hold_ones", 0, 32'(xo[0]), 32'hF);

    mode = 1; sweep(0, lat); chk("tt_x0", 0, 32'(to[0]), 32'hAAAA);
    mode = 2; sweep(0, lat); chk("tt_x3", 0, 32'(to[0]), 32'hFF00);
    mode = 3; sweep(0, lat); chk("tt_x1x2", 0, 32'(to[0]), 32'hC0C0);

    // SETTLE=0 parity
    mode = 4; sweep(1, lat);
    chk("lat_settle0", 1, lat, 17);
    chk("tt_parity", 1, 32'(to[1]), 32'h6996);

    // Extra start pulses during a sweep are ignored
    mode = 1; pulse(0);
    nd = 0; d1 = 0;
    for (int n = 2; n <= 70; n++) begin
      @(negedge clk);
      if (dn[0]) begin nd++; d1 = n; end
      st[0] = (n == 5 || n == 30);
    end
    st[0] = 1'b0;
    chk("ign_ndone", 0, nd, 1);
    chk("ign_done_at", 0, d1, 49);
    chk("ign_tt", 0, 32'(to[0]), 32'hAAAA);

    // Reset mid-sweep
    mode = 3; pulse(0);
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_x", 0, 32'(xo[0]), 0);
    chk("mid_rst_busy", 0, 32'(bo[0]), 0);
    chk("mid_rst_tt", 0, 32'(to[0]), 0);
    chk("mid_rst_valid", 0, 32'(vo[0]), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    sweep(0, lat);
    chk("post_rst_lat", 0, lat, 49);
    chk("post_rst_tt", 0, 32'(to[0]), 32'hC0C0);

    // start held high: back-to-back sweeps with a one-cycle IDLE gap
    mode = 2;
    @(negedge clk); st[0] = 1'b1;
    nd = 0; d1 = 0; d2 = 0;
    for (int n = 1; n <= 130; n++) begin
      @(negedge clk);
      if (dn[0]) begin
        nd++;
        if (nd == 1) d1 = n; else d2 = n;
      end
      st[0] = (n < 60);
    end
    chk("b2b_ndone", 0, nd, 2);
    chk("b2b_first", 0, d1, 49);
    chk("b2b_second", 0, d2, 99);
    chk("b2b_tt", 0, 32'(to[0]), 32'hFF00);

`ifdef TT_COMPARE_EN
    mode = 1; ett = 16'hAAAA; sweep(0, lat);
    chk("cmp_match", 0, 32'(mo[0]), 0);
    ett = 16'hAAAB; sweep(0, lat);
    chk("cmp_mismatch", 0, 32'(mo[0]), 1);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
